// File: rtl/bp_me_pkg.sv
// Shared definitions for the BedRock burst-stream ME blocks: FSM state codes,
// burst header base layout, and the beat-count helper.
package bp_me_pkg;

   localparam int msg_type_width_lp  = 4;
   localparam int msg_size_width_lp  = 3;
   localparam int paddr_width_lp     = 40;
   localparam int msg_type_values_lp = 1 << msg_type_width_lp;
   localparam int msg_size_lsb_lp    = msg_type_width_lp;

   localparam logic [0:0] e_header = 1'b0;
   localparam logic [0:0] e_data   = 1'b1;

   // Header = {payload, base}; msg_type sits in the LSBs so field offsets
   // do not depend on the payload width.
   typedef struct packed {
      logic [paddr_width_lp-1:0]    addr;
      logic [msg_size_width_lp-1:0] size;
      logic [msg_type_width_lp-1:0] msg_type;
   } bp_bedrock_burst_hdr_base_s;

   localparam int hdr_base_width_lp = $bits(bp_bedrock_burst_hdr_base_s);

   // Beats in a message of 2**size bytes: at least one, capped at a full block.
   function automatic int bp_me_nbeats(input logic [msg_size_width_lp-1:0] size,
                                       input int data_bytes,
                                       input int max_beats);
      int bytes;
      int beats;
      bytes = 1 << size;
      beats = bytes / data_bytes;
      if (beats < 1)
         beats = 1;
      if (beats > max_beats)
         beats = max_beats;
      return beats;
   endfunction

endpackage

// File: rtl/bp_me_rr_pick.sv
// Rotating-priority picker: first requester at or above the pointer, wrapping.
module bp_me_rr_pick
   import bp_me_pkg::*;
 #(parameter  int num_inputs_p = 2
  ,localparam int ptr_width_lp = (num_inputs_p > 1) ? $clog2(num_inputs_p) : 1
  )
  (input  logic [num_inputs_p-1:0] reqs_i
  ,input  logic [ptr_width_lp-1:0] ptr_i
  ,output logic [num_inputs_p-1:0] grant_oh_o
  ,output logic [ptr_width_lp-1:0] grant_idx_o
  ,output logic                    v_o
  );

   int                      idx;
   logic [ptr_width_lp-1:0] sel;
   logic                    found;

   always_comb begin
      grant_oh_o  = '0;
      grant_idx_o = '0;
      found       = 1'b0;
      idx         = 0;
      sel         = '0;
      for (int k = 0; k < num_inputs_p; k++) begin
         idx = (int'(ptr_i) + k) % num_inputs_p;
         sel = ptr_width_lp'(idx);
         if (!found && reqs_i[sel]) begin
            found            = 1'b1;
            grant_oh_o[sel]  = 1'b1;
            grant_idx_o      = sel;
         end
      end
   end

   assign v_o = |reqs_i;

endmodule

// File: rtl/bp_me_burst_stream_arbiter.sv
// Round-robin arbiter sharing one BedRock burst link among several burst masters;
// the grant is held from header handshake through the last data beat.
module bp_me_burst_stream_arbiter
   import bp_me_pkg::*;
 #(parameter  int                             num_inputs_p      = 2
  ,parameter  int                             data_width_p      = 64
  ,parameter  int                             cce_block_width_p = 512
  ,parameter  int                             payload_width_p   = 16
  ,parameter  logic [msg_type_values_lp-1:0]  payload_mask_p    = '0
  ,localparam int                             hdr_width_lp      = payload_width_p + hdr_base_width_lp
  )
  (input  logic                                   clk_i
  ,input  logic                                   reset_i

  ,input  logic [num_inputs_p*hdr_width_lp-1:0]   msg_header_i
  ,input  logic [num_inputs_p-1:0]                msg_header_v_i
  ,output logic [num_inputs_p-1:0]                msg_header_ready_and_o
  ,input  logic [num_inputs_p*data_width_p-1:0]   msg_data_i
  ,input  logic [num_inputs_p-1:0]                msg_data_v_i
  ,output logic [num_inputs_p-1:0]                msg_data_ready_and_o

  ,output logic [hdr_width_lp-1:0]                msg_header_o
  ,output logic                                   msg_header_v_o
  ,input  logic                                   msg_header_ready_and_i
  ,output logic [data_width_p-1:0]                msg_data_o
  ,output logic                                   msg_data_v_o
  ,input  logic                                   msg_data_ready_and_i
  );

   localparam int ptr_width_lp   = (num_inputs_p > 1) ? $clog2(num_inputs_p) : 1;
   localparam int max_beats_lp   = cce_block_width_p / data_width_p;
   localparam int beats_width_lp = $clog2(max_beats_lp + 1);

   logic [0:0]                   state_r;
   logic [ptr_width_lp-1:0]      rr_ptr_r, rr_next, grant_r, pick_idx;
   logic [beats_width_lp-1:0]    beats_r;
   logic [num_inputs_p-1:0]      pick_oh;
   logic                         pick_v;
   logic                         in_header, in_data;
   logic                         hdr_hs, data_hs, has_data;
   logic [msg_type_width_lp-1:0] pick_type;
   logic [msg_size_width_lp-1:0] pick_size;

   bp_me_rr_pick
    #(.num_inputs_p(num_inputs_p))
    pick
     (.reqs_i      (msg_header_v_i)
     ,.ptr_i       (rr_ptr_r)
     ,.grant_oh_o  (pick_oh)
     ,.grant_idx_o (pick_idx)
     ,.v_o         (pick_v)
     );

   // Reset gates every valid and ready so nothing handshakes while the link is held.
   assign in_header = ~reset_i & (state_r == e_header);
   assign in_data   = ~reset_i & (state_r == e_data);

   assign msg_header_o           = msg_header_i[pick_idx*hdr_width_lp +: hdr_width_lp];
   assign msg_header_v_o         = in_header & pick_v;
   assign msg_header_ready_and_o = in_header ? (pick_oh & {num_inputs_p{msg_header_ready_and_i}}) : '0;

   assign msg_data_o             = msg_data_i[grant_r*data_width_p +: data_width_p];
   assign msg_data_v_o           = in_data & msg_data_v_i[grant_r];
   assign msg_data_ready_and_o   = in_data ? ({{(num_inputs_p-1){1'b0}}, msg_data_ready_and_i} << grant_r) : '0;

   assign hdr_hs    = msg_header_v_o & msg_header_ready_and_i;
   assign data_hs   = msg_data_v_o & msg_data_ready_and_i;
   assign pick_type = msg_header_o[msg_type_width_lp-1:0];
   assign pick_size = msg_header_o[msg_size_lsb_lp +: msg_size_width_lp];
   assign has_data  = payload_mask_p[pick_type];

   always_comb begin
      rr_next = '0;
      if (pick_idx != ptr_width_lp'(num_inputs_p - 1))
         rr_next = pick_idx + ptr_width_lp'(1);
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r  <= e_header;
         rr_ptr_r <= '0;
         grant_r  <= '0;
         beats_r  <= '0;
      end else if (hdr_hs) begin
         rr_ptr_r <= rr_next;
         grant_r  <= pick_idx;
         if (has_data) begin
            beats_r <= beats_width_lp'(bp_me_nbeats(pick_size, data_width_p / 8, max_beats_lp));
            state_r <= e_data;
         end
      end else if (data_hs) begin
         beats_r <= beats_r - beats_width_lp'(1);
         if (beats_r == beats_width_lp'(1))
            state_r <= e_header;
      end
   end

endmodule

// File: tb/tb_bp_me_burst_stream_arbiter.sv
// Self-checking bench for bp_me_burst_stream_arbiter: directed scenarios plus
// randomized traffic against a transaction-level reference model.
module tb_bp_me_burst_stream_arbiter;
   import bp_me_pkg::*;

   localparam int          n_lp  = 2;
   localparam int          dw_lp = 64;
   localparam int          pw_lp = 16;
   localparam int          hw_lp = pw_lp + hdr_base_width_lp;
   localparam logic [15:0] mask_lp = 16'h000A;   // types 1 and 3 carry data
   localparam logic [3:0]  t_rd  = 4'd0;
   localparam logic [3:0]  t_wr  = 4'd1;
   localparam logic [3:0]  t_amo = 4'd3;

   logic clk = 1'b0;
   logic reset = 1'b0;

   logic [hw_lp-1:0]      hdr     [n_lp];
   logic [dw_lp-1:0]      data_in [n_lp];
   logic [n_lp*hw_lp-1:0] hdr_flat;
   logic [n_lp*dw_lp-1:0] data_flat;
   logic [n_lp-1:0]       hdr_v, data_v, hdr_rdy, data_rdy;
   logic                  down_hdr_rdy, down_data_rdy;
   logic [hw_lp-1:0]      o_hdr;
   logic                  o_hdr_v, o_data_v;
   logic [dw_lp-1:0]      o_data;

   int checks = 0;
   int failures = 0;

   // Reference model state: pointer, and the burst in flight (owner, beats left).
   int m_ptr, m_owner, m_left;
   bit m_busy;
   logic            e_hdr_v, e_data_v;
   logic [n_lp-1:0] e_hdr_rdy, e_data_rdy;
   logic [hw_lp-1:0] e_hdr;
   logic [dw_lp-1:0] e_data;

   always_comb begin
      hdr_flat  = '0;
      data_flat = '0;
      for (int i = 0; i < n_lp; i++) begin
         hdr_flat[i*hw_lp +: hw_lp]  = hdr[i];
         data_flat[i*dw_lp +: dw_lp] = data_in[i];
      end
   end

   bp_me_burst_stream_arbiter
    #(.num_inputs_p(n_lp), .data_width_p(dw_lp), .cce_block_width_p(512)
     ,.payload_width_p(pw_lp), .payload_mask_p(mask_lp))
    dut
     (.clk_i(clk), .reset_i(reset)
     ,.msg_header_i(hdr_flat), .msg_header_v_i(hdr_v), .msg_header_ready_and_o(hdr_rdy)
     ,.msg_data_i(data_flat), .msg_data_v_i(data_v), .msg_data_ready_and_o(data_rdy)
     ,.msg_header_o(o_hdr), .msg_header_v_o(o_hdr_v), .msg_header_ready_and_i(down_hdr_rdy)
     ,.msg_data_o(o_data), .msg_data_v_o(o_data_v), .msg_data_ready_and_i(down_data_rdy)
     );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog expired time=%0t", $time);
      $fatal(1, "watchdog");
   end

   function automatic logic [hw_lp-1:0] make_hdr(input logic [3:0] t, input logic [2:0] s,
                                                 input logic [39:0] a, input logic [15:0] p);
      bp_bedrock_burst_hdr_base_s b;
      b.addr = a;
      b.size = s;
      b.msg_type = t;
      return {p, b};
   endfunction

   function automatic logic [dw_lp-1:0] rnd64();
      return {$urandom, $urandom};
   endfunction

   function automatic int m_pick();
      for (int k = 0; k < n_lp; k++)
         if (hdr_v[(m_ptr + k) % n_lp]) return (m_ptr + k) % n_lp;
      return -1;
   endfunction

   function automatic bit carries_data(input logic [hw_lp-1:0] h);
      bp_bedrock_burst_hdr_base_s b;
      b = h[hdr_base_width_lp-1:0];
      return mask_lp[b.msg_type];
   endfunction

   // 2**size bytes over 8-byte beats, at least one beat, at most a 64-byte block.
   function automatic int beats_of(input logic [hw_lp-1:0] h);
      bp_bedrock_burst_hdr_base_s b;
      int bytes;
      b = h[hdr_base_width_lp-1:0];
      bytes = 1 << b.size;
      if (bytes <= 8) return 1;
      if (bytes >= 64) return 8;
      return bytes / 8;
   endfunction

   task automatic model_reset();
      m_busy = 1'b0;
      m_ptr = 0;
      m_owner = 0;
      m_left = 0;
   endtask

   task automatic model_outputs();
      int p;
      p = m_pick();
      e_hdr_v = !reset && !m_busy && (p >= 0);
      e_hdr_rdy = '0;
      if (e_hdr_v && down_hdr_rdy) e_hdr_rdy[p] = 1'b1;
      e_hdr = (p >= 0) ? hdr[p] : '0;
      e_data_v = !reset && m_busy && data_v[m_owner];
      e_data_rdy = '0;
      if (!reset && m_busy && down_data_rdy) e_data_rdy[m_owner] = 1'b1;
      e_data = data_in[m_owner];
   endtask

   task automatic model_advance();
      int p;
      p = m_pick();
      if (reset) begin
         model_reset();
      end else if (!m_busy) begin
         if (p >= 0 && down_hdr_rdy) begin
            m_ptr = (p + 1) % n_lp;
            if (carries_data(hdr[p])) begin
               m_busy = 1'b1;
               m_owner = p;
               m_left = beats_of(hdr[p]);
            end
         end
      end else if (data_v[m_owner] && down_data_rdy) begin
         m_left--;
         if (m_left == 0) m_busy = 1'b0;
      end
   endtask

   task automatic sample();
      @(negedge clk);
   endtask

   task automatic step();
      model_advance();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < n_lp; i++) begin
         hdr[i] = make_hdr(t_rd, 3'd3, 40'(i + 1), 16'h0);
         data_in[i] = rnd64();
      end
      hdr_v = '1; data_v = '1; down_hdr_rdy = 1'b1; down_data_rdy = 1'b1;
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      sample();
      checks++; if (o_hdr_v !== 1'b0) begin failures++; $display("FAIL rst_hdr_v got=%b exp=0", o_hdr_v); end
      checks++; if (hdr_rdy !== 2'b00) begin failures++; $display("FAIL rst_hdr_rdy got=%b exp=00", hdr_rdy); end
      checks++; if (o_data_v !== 1'b0) begin failures++; $display("FAIL rst_data_v got=%b exp=0", o_data_v); end
      checks++; if (data_rdy !== 2'b00) begin failures++; $display("FAIL rst_data_rdy got=%b exp=00", data_rdy); end
      @(posedge clk); #1;
      down_hdr_rdy = 1'b0;
      reset = 1'b0;
      model_reset();
      sample();
      checks++; if (o_hdr_v !== 1'b1) begin failures++; $display("FAIL post_rst_hdr_v got=%b exp=1", o_hdr_v); end
      checks++; if (o_hdr !== hdr[0]) begin failures++; $display("FAIL post_rst_hdr got=%h exp=%h", o_hdr, hdr[0]); end
      checks++; if (hdr_rdy !== 2'b00) begin failures++; $display("FAIL post_rst_hdr_rdy got=%b exp=00", hdr_rdy); end
      step();
   endtask

   task automatic test_alternate();
      logic [n_lp-1:0] exp_oh;
      hdr_v = '1; data_v = '0; down_hdr_rdy = 1'b1;
      for (int k = 0; k < 8; k++) begin
         for (int i = 0; i < n_lp; i++)
            hdr[i] = make_hdr(t_rd, 3'($urandom_range(0, 7)), 40'(rnd64()), 16'($urandom));
         exp_oh = n_lp'(1) << (k % 2);
         sample();
         checks++; if (hdr_rdy !== exp_oh) begin failures++; $display("FAIL alt_grant[%0d] got=%b exp=%b", k, hdr_rdy, exp_oh); end
         checks++; if (o_hdr !== hdr[k % 2]) begin failures++; $display("FAIL alt_hdr[%0d] got=%h exp=%h", k, o_hdr, hdr[k % 2]); end
         step();
      end
      hdr_v = '0;
   endtask

   task automatic test_burst64();
      logic [dw_lp-1:0] w [8];
      for (int i = 0; i < 8; i++) w[i] = rnd64();
      hdr[1] = make_hdr(t_wr, 3'd6, 40'h1000, 16'h11);
      hdr_v = 2'b10; data_v = '0; down_hdr_rdy = 1'b1; down_data_rdy = 1'b1;
      sample();
      checks++; if (hdr_rdy !== 2'b10) begin failures++; $display("FAIL b64_hdr_grant got=%b exp=10", hdr_rdy); end
      step();
      hdr[0] = make_hdr(t_rd, 3'd3, 40'h2000, 16'h22);
      hdr_v = 2'b01; data_v = 2'b10;
      for (int b = 0; b < 8; b++) begin
         data_in[1] = w[b];
         sample();
         checks++; if (o_data_v !== 1'b1 || o_data !== w[b]) begin failures++; $display("FAIL b64_beat[%0d] got=%b/%h exp=1/%h", b, o_data_v, o_data, w[b]); end
         checks++; if (data_rdy !== 2'b10) begin failures++; $display("FAIL b64_data_rdy[%0d] got=%b exp=10", b, data_rdy); end
         checks++; if (hdr_rdy !== 2'b00 || o_hdr_v !== 1'b0) begin failures++; $display("FAIL b64_hdr_held[%0d] got=%b/%b exp=00/0", b, hdr_rdy, o_hdr_v); end
         step();
      end
      data_v = '0;
      sample();
      checks++; if (hdr_rdy !== 2'b01) begin failures++; $display("FAIL b64_next_grant got=%b exp=01", hdr_rdy); end
      checks++; if (o_data_v !== 1'b0) begin failures++; $display("FAIL b64_data_idle got=%b exp=0", o_data_v); end
      step();
      hdr_v = '0;
   endtask

   task automatic test_single_beat();
      logic [dw_lp-1:0] w;
      w = rnd64();
      hdr[1] = make_hdr(t_amo, 3'd2, 40'h3004, 16'h33);
      data_in[1] = w;
      hdr_v = 2'b10; data_v = 2'b10; down_hdr_rdy = 1'b1; down_data_rdy = 1'b1;
      sample();
      checks++; if (hdr_rdy !== 2'b10) begin failures++; $display("FAIL sb_hdr_grant got=%b exp=10", hdr_rdy); end
      checks++; if (o_data_v !== 1'b0 || data_rdy !== 2'b00) begin failures++; $display("FAIL sb_data_in_hdr got=%b/%b exp=0/00", o_data_v, data_rdy); end
      step();
      hdr_v = 2'b00;
      sample();
      checks++; if (o_data_v !== 1'b1 || o_data !== w || data_rdy !== 2'b10) begin failures++; $display("FAIL sb_beat got=%b/%h/%b exp=1/%h/10", o_data_v, o_data, data_rdy, w); end
      step();
      hdr[0] = make_hdr(t_rd, 3'd0, 40'h3100, 16'h34);
      hdr_v = 2'b01; data_v = 2'b00;
      sample();
      checks++; if (o_hdr_v !== 1'b1 || hdr_rdy !== 2'b01) begin failures++; $display("FAIL sb_back_to_hdr got=%b/%b exp=1/01", o_hdr_v, hdr_rdy); end
      step();
      hdr_v = '0;
   endtask

   task automatic test_toggle_ready();
      logic [dw_lp-1:0] w [8];
      logic [dw_lp-1:0] recv [$];
      int src;
      for (int i = 0; i < 8; i++) w[i] = rnd64();
      hdr[1] = make_hdr(t_wr, 3'd6, 40'h4000, 16'h44);
      hdr_v = 2'b10; data_v = '0; down_hdr_rdy = 1'b1; down_data_rdy = 1'b0;
      sample();
      checks++; if (hdr_rdy !== 2'b10) begin failures++; $display("FAIL tog_hdr_grant got=%b exp=10", hdr_rdy); end
      step();
      hdr_v = '0;
      src = 0;
      for (int c = 0; c < 16; c++) begin
         down_data_rdy = (c % 2 == 0);
         data_v = (src < 8) ? 2'b10 : 2'b00;
         data_in[1] = w[(src < 8) ? src : 7];
         sample();
         checks++; if (data_rdy !== (down_data_rdy ? 2'b10 : 2'b00)) begin failures++; $display("FAIL tog_data_rdy[%0d] got=%b exp=%b", c, data_rdy, down_data_rdy ? 2'b10 : 2'b00); end
         if (o_data_v && down_data_rdy) recv.push_back(o_data);
         if (data_v[1] && data_rdy[1]) src++;
         step();
      end
      checks++; if (recv.size() != 8) begin failures++; $display("FAIL tog_beat_count got=%0d exp=8", recv.size()); end
      for (int i = 0; i < 8; i++) begin
         if (i < recv.size()) begin
            checks++; if (recv[i] !== w[i]) begin failures++; $display("FAIL tog_order[%0d] got=%h exp=%h", i, recv[i], w[i]); end
         end
      end
      data_v = 2'b10; down_data_rdy = 1'b1;
      sample();
      checks++; if (data_rdy !== 2'b00 || o_data_v !== 1'b0) begin failures++; $display("FAIL tog_burst_closed got=%b/%b exp=00/0", data_rdy, o_data_v); end
      step();
      data_v = '0;
   endtask

   task automatic test_early_data();
      logic [dw_lp-1:0] w [8];
      logic [dw_lp-1:0] m0w;
      m0w = rnd64();
      for (int i = 0; i < 8; i++) w[i] = rnd64();
      hdr[1] = make_hdr(t_wr, 3'd6, 40'h5000, 16'h55);
      hdr_v = 2'b10; data_v = '0; down_hdr_rdy = 1'b1; down_data_rdy = 1'b1;
      sample();
      checks++; if (hdr_rdy !== 2'b10) begin failures++; $display("FAIL early_hdr1 got=%b exp=10", hdr_rdy); end
      step();
      hdr[0] = make_hdr(t_wr, 3'd4, 40'h5100, 16'h56);
      hdr_v = 2'b01; data_v = 2'b11; data_in[0] = m0w;
      for (int b = 0; b < 8; b++) begin
         data_in[1] = w[b];
         sample();
         checks++; if (data_rdy[0] !== 1'b0) begin failures++; $display("FAIL early_m0_acked[%0d] got=%b exp=0", b, data_rdy[0]); end
         checks++; if (o_data !== w[b]) begin failures++; $display("FAIL early_m1_word[%0d] got=%h exp=%h", b, o_data, w[b]); end
         step();
      end
      data_v = 2'b01;
      sample();
      checks++; if (hdr_rdy !== 2'b01 || data_rdy !== 2'b00) begin failures++; $display("FAIL early_m0_hdr got=%b/%b exp=01/00", hdr_rdy, data_rdy); end
      step();
      hdr_v = '0;
      for (int b = 0; b < 2; b++) begin
         sample();
         checks++; if (data_rdy !== 2'b01 || o_data !== m0w) begin failures++; $display("FAIL early_m0_beat[%0d] got=%b/%h exp=01/%h", b, data_rdy, o_data, m0w); end
         step();
      end
      data_v = '0;
   endtask

   task automatic test_async_reset();
      hdr[0] = make_hdr(t_wr, 3'd6, 40'h6000, 16'h66);
      hdr_v = 2'b01; data_v = '0; down_hdr_rdy = 1'b1; down_data_rdy = 1'b1;
      sample();
      checks++; if (hdr_rdy !== 2'b01) begin failures++; $display("FAIL ar_hdr0 got=%b exp=01", hdr_rdy); end
      step();
      hdr[1] = make_hdr(t_rd, 3'd3, 40'h6100, 16'h67);
      hdr_v = 2'b11; data_v = 2'b11;
      for (int b = 0; b < 2; b++) begin
         data_in[0] = rnd64();
         sample();
         checks++; if (data_rdy !== 2'b01) begin failures++; $display("FAIL ar_beat[%0d] got=%b exp=01", b, data_rdy); end
         step();
      end
      data_in[0] = rnd64();
      #1 reset = 1'b1;
      #1;
      checks++; if (o_hdr_v !== 1'b0 || o_data_v !== 1'b0) begin failures++; $display("FAIL ar_valids got=%b/%b exp=0/0", o_hdr_v, o_data_v); end
      checks++; if (hdr_rdy !== 2'b00 || data_rdy !== 2'b00) begin failures++; $display("FAIL ar_readies got=%b/%b exp=00/00", hdr_rdy, data_rdy); end
      model_reset();
      @(posedge clk); #1;
      reset = 1'b0;
      data_v = '0;
      hdr[0] = make_hdr(t_rd, 3'd3, 40'h6200, 16'h68);
      sample();
      checks++; if (hdr_rdy !== 2'b01 || o_hdr !== hdr[0]) begin failures++; $display("FAIL ar_regrant got=%b/%h exp=01/%h", hdr_rdy, o_hdr, hdr[0]); end
      checks++; if (o_data_v !== 1'b0) begin failures++; $display("FAIL ar_state_hdr got=%b exp=0", o_data_v); end
      step();
      hdr_v = '0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 400; c++) begin
         hdr_v = n_lp'($urandom);
         data_v = n_lp'($urandom);
         down_hdr_rdy = 1'($urandom);
         down_data_rdy = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < n_lp; i++) begin
            hdr[i] = make_hdr(4'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), 40'(rnd64()), 16'($urandom));
            data_in[i] = rnd64();
         end
         sample();
         model_outputs();
         checks++; if (o_hdr_v !== e_hdr_v || hdr_rdy !== e_hdr_rdy) begin failures++; $display("FAIL rnd_hdr_ctl[%0d] got=%b/%b exp=%b/%b", c, o_hdr_v, hdr_rdy, e_hdr_v, e_hdr_rdy); end
         checks++; if (o_data_v !== e_data_v || data_rdy !== e_data_rdy) begin failures++; $display("FAIL rnd_data_ctl[%0d] got=%b/%b exp=%b/%b", c, o_data_v, data_rdy, e_data_v, e_data_rdy); end
         if (e_hdr_v) begin
            checks++; if (o_hdr !== e_hdr) begin failures++; $display("FAIL rnd_hdr[%0d] got=%h exp=%h", c, o_hdr, e_hdr); end
         end
         if (e_data_v) begin
            checks++; if (o_data !== e_data) begin failures++; $display("FAIL rnd_data[%0d] got=%h exp=%h", c, o_data, e_data); end
         end
         step();
      end
      hdr_v = '0;
      data_v = '0;
   endtask

   initial begin
      model_reset();
      hdr_v = '0; data_v = '0; down_hdr_rdy = 1'b0; down_data_rdy = 1'b0;
      for (int i = 0; i < n_lp; i++) begin
         hdr[i] = '0;
         data_in[i] = '0;
      end
      test_reset();
      test_alternate();
      test_burst64();
      test_single_beat();
      test_toggle_ready();
      test_early_data();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
